// File: rtl/tpsram_fifo_ctrl.sv
// Streaming FIFO controller around a two-port RAM with registered read output.
// Read data is prefetched into a small skid buffer so the consumer sees no RAM latency.
module tpsram_fifo_ctrl #(
   parameter int AW        = 11,
   parameter int DW        = 32,
   parameter int RD_LAT    = 2,
   parameter int AFULL_LVL = 1984
) (
   input  logic          CLK,
   input  logic          RESETN,
   input  logic          FLUSH,
   input  logic [DW-1:0] S_DATA,
   input  logic          S_VALID,
   output logic          S_READY,
   output logic [DW-1:0] M_DATA,
   output logic          M_VALID,
   input  logic          M_READY,
   output logic [AW-1:0] W_ADDR,
   output logic [DW-1:0] W_DATA,
   output logic          W_EN,
   output logic [AW-1:0] R_ADDR,
   input  logic [DW-1:0] R_DATA,
   output logic [AW+1:0] LEVEL,
   output logic          ALMOST_FULL,
   output logic          OVERFLOW
);

   localparam int SK  = RD_LAT + 1;
   localparam int SPW = (SK > 1) ? $clog2(SK) : 1;
   localparam int CW  = $clog2(2 * RD_LAT + 3);

   logic [AW:0]     wptr;
   logic [AW:0]     rptr;
   logic [AW:0]     occ;
   logic            full;
   logic            empty;
   logic            clr;
   logic            wr;
   logic            rd_iss;
   logic            pop;
   logic            capture;
   logic [RD_LAT-1:0] pipe;
   logic [CW-1:0]   inflight;
   logic [CW-1:0]   skid_cnt;
   logic [SPW-1:0]  head;
   logic [SPW-1:0]  tail;
   logic [DW-1:0]   skid_mem [SK];

   assign clr     = !RESETN || FLUSH;
   assign occ     = wptr - rptr;
   assign full    = (occ == {1'b1, {AW{1'b0}}});
   assign empty   = (occ == '0);

   assign S_READY = !full;
   assign wr      = S_VALID && !full && !clr;
   assign W_EN    = wr;
   assign W_ADDR  = wptr[AW-1:0];
   assign W_DATA  = S_DATA;
   assign R_ADDR  = rptr[AW-1:0];

   assign M_VALID = (skid_cnt != '0);
   assign M_DATA  = skid_mem[head];
   assign pop     = M_VALID && M_READY;
   assign capture = pipe[RD_LAT-1];

   always_comb begin
      inflight = '0;
      for (int i = 0; i < RD_LAT; i++) begin
         inflight = inflight + CW'(pipe[i]);
      end
   end

   // A pop this cycle frees a skid slot before any new read can land, so it
   // counts as credit; without it steady-state streaming would stall every few words.
   assign rd_iss = !empty && !clr && ((inflight + skid_cnt) < (CW'(SK) + CW'(pop)));

   assign ALMOST_FULL = (LEVEL >= (AW+2)'(AFULL_LVL));

   always_ff @(posedge CLK) begin
      if (clr) begin
         wptr     <= '0;
         rptr     <= '0;
         pipe     <= '0;
         skid_cnt <= '0;
         head     <= '0;
         tail     <= '0;
         LEVEL    <= '0;
         OVERFLOW <= 1'b0;
      end else begin
         if (wr) wptr <= wptr + 1'b1;
         if (rd_iss) rptr <= rptr + 1'b1;
         pipe <= (pipe << 1) | RD_LAT'(rd_iss);
         if (capture) tail <= (tail == SPW'(SK - 1)) ? '0 : tail + 1'b1;
         if (pop) head <= (head == SPW'(SK - 1)) ? '0 : head + 1'b1;
         case ({capture, pop})
            2'b10:   skid_cnt <= skid_cnt + 1'b1;
            2'b01:   skid_cnt <= skid_cnt - 1'b1;
            default: skid_cnt <= skid_cnt;
         endcase
         // Words only enter on a write and leave on a pop; issue/capture just move them inside.
         case ({wr, pop})
            2'b10:   LEVEL <= LEVEL + 1'b1;
            2'b01:   LEVEL <= LEVEL - 1'b1;
            default: LEVEL <= LEVEL;
         endcase
         if (S_VALID && full) OVERFLOW <= 1'b1;
      end
   end

   always_ff @(posedge CLK) begin
      if (capture && !clr) skid_mem[tail] <= R_DATA;
   end

endmodule

// File: tb/tb_tpsram_fifo_ctrl.sv
// Bench for tpsram_fifo_ctrl with a behavioural 2048x32 RAM (two-cycle read latency).
// Written words go into a scoreboard queue; every accepted output word is popped and compared.
module tb_tpsram_fifo_ctrl;
   localparam int AW = 11;
   localparam int DW = 32;

   logic          CLK = 1'b0;
   logic          RESETN, FLUSH, S_VALID, M_READY;
   logic [DW-1:0] S_DATA;
   logic          S_READY, M_VALID, W_EN, ALMOST_FULL, OVERFLOW;
   logic [DW-1:0] M_DATA, W_DATA, R_DATA;
   logic [AW-1:0] W_ADDR, R_ADDR;
   logic [AW+1:0] LEVEL;

   tpsram_fifo_ctrl #(.AW(AW), .DW(DW), .RD_LAT(2), .AFULL_LVL(1984)) dut (
      .CLK(CLK), .RESETN(RESETN), .FLUSH(FLUSH),
      .S_DATA(S_DATA), .S_VALID(S_VALID), .S_READY(S_READY),
      .M_DATA(M_DATA), .M_VALID(M_VALID), .M_READY(M_READY),
      .W_ADDR(W_ADDR), .W_DATA(W_DATA), .W_EN(W_EN),
      .R_ADDR(R_ADDR), .R_DATA(R_DATA),
      .LEVEL(LEVEL), .ALMOST_FULL(ALMOST_FULL), .OVERFLOW(OVERFLOW)
   );

   always #5 CLK = ~CLK;

   logic [DW-1:0] ram [2048];
   logic [AW-1:0] ra_q;
   logic [DW-1:0] rd_q;
   always @(posedge CLK) begin
      if (W_EN) ram[W_ADDR] <= W_DATA;
      ra_q <= R_ADDR;
      rd_q <= ram[ra_q];
   end
   assign R_DATA = rd_q;

   int            n_tests = 0;
   int            n_fail  = 0;
   logic [DW-1:0] sb [$];
   bit            chk_en = 1'b0;
   logic [DW-1:0] exp_word;
   logic [AW-1:0] ra_prev = '0;
   bit            ra_wrapped = 1'b0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   always @(negedge CLK) begin
      if (chk_en && M_VALID && M_READY) begin
         n_tests++;
         assert (sb.size() != 0) else begin
            n_fail++;
            $error("FAIL unexpected_output observed=0x%0h expected=no_word", M_DATA);
         end
         if (sb.size() != 0) begin
            exp_word = sb.pop_front();
            check("m_data", {32'h0, M_DATA}, {32'h0, exp_word});
         end
      end
      if (ra_prev == 11'd2047 && R_ADDR == 11'd0) ra_wrapped = 1'b1;
      ra_prev = R_ADDR;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic wait_drain(input string tag, input int budget);
      int n = 0;
      while (sb.size() != 0 && n < budget) begin
         tick();
         n++;
      end
      check(tag, sb.size(), 0);
   endtask

   int wr_count;
   int bad_rdy, bad_wa, gaps, stale, written, cyc;

   initial begin
      RESETN = 1'b0; FLUSH = 1'b0; S_VALID = 1'b0; M_READY = 1'b0; S_DATA = '0;
      repeat (3) tick();
      RESETN = 1'b1;
      tick();
      check("rst_m_valid", M_VALID, 0);
      check("rst_s_ready", S_READY, 1);
      check("rst_w_en", W_EN, 0);
      check("rst_level", LEVEL, 0);
      check("rst_afull", ALMOST_FULL, 0);
      check("rst_ovf", OVERFLOW, 0);
      chk_en   = 1'b1;
      wr_count = 0;

      // single word latency
      M_READY = 1'b1;
      S_DATA  = 32'hDEADBEEF;
      S_VALID = 1'b1;
      #1;
      check("single_w_en", W_EN, 1);
      check("single_w_addr", W_ADDR, 0);
      check("single_w_data", W_DATA, 32'hDEADBEEF);
      sb.push_back(32'hDEADBEEF);
      wr_count++;
      tick();
      S_VALID = 1'b0;
      check("single_level", LEVEL, 1);
      for (int i = 1; i < 4; i++) begin
         check($sformatf("single_early_%0d", i), M_VALID, 0);
         tick();
      end
      check("single_valid_at_lat", M_VALID, 1);
      check("single_data_at_lat", M_DATA, 32'hDEADBEEF);
      tick();
      check("single_level_zero", LEVEL, 0);
      check("single_empty", M_VALID, 0);

      // fill with consumer stalled
      M_READY = 1'b0;
      bad_rdy = 0;
      bad_wa  = 0;
      for (int i = 0; i < 2051; i++) begin
         S_VALID = 1'b1;
         S_DATA  = i;
         #1;
         if (!S_READY) bad_rdy++;
         if (W_ADDR !== 11'(wr_count)) bad_wa++;
         if (i == 1983) check("afull_below", ALMOST_FULL, 0);
         if (i == 1984) check("afull_at", ALMOST_FULL, 1);
         sb.push_back(i);
         wr_count++;
         tick();
      end
      S_VALID = 1'b0;
      check("fill_ready_drops", bad_rdy, 0);
      check("fill_waddr", bad_wa, 0);
      repeat (4) tick();
      check("full_s_ready", S_READY, 0);
      check("full_level", LEVEL, 2051);
      check("full_afull", ALMOST_FULL, 1);
      check("full_ovf_clear", OVERFLOW, 0);
      check("full_head", M_DATA, 0);
      S_VALID = 1'b1;
      S_DATA  = 32'h00000BAD;
      #1;
      check("ovf_no_write", W_EN, 0);
      tick();
      S_VALID = 1'b0;
      check("ovf_set", OVERFLOW, 1);
      check("ovf_level", LEVEL, 2051);
      M_READY = 1'b1;
      wait_drain("fill_drain", 2300);
      repeat (3) tick();
      check("fill_level_zero", LEVEL, 0);
      check("fill_raddr_wrap", ra_wrapped, 1);

      // random handshakes, long stream
      written = 0;
      cyc     = 0;
      bad_wa  = 0;
      while (written < 10000 && cyc < 60000) begin
         S_VALID = 1'($urandom_range(0, 1));
         M_READY = 1'($urandom_range(0, 1));
         S_DATA  = 32'h1000_0000 + written;
         #1;
         if (S_VALID && S_READY) begin
            if (W_ADDR !== 11'(wr_count)) bad_wa++;
            sb.push_back(S_DATA);
            wr_count++;
            written++;
         end
         tick();
         cyc++;
      end
      S_VALID = 1'b0;
      M_READY = 1'b1;
      check("rand_written", written, 10000);
      check("rand_waddr", bad_wa, 0);
      wait_drain("rand_drain", 3000);
      repeat (3) tick();
      check("rand_level_zero", LEVEL, 0);

      // reset in the middle of a stream
      S_VALID = 1'b1;
      for (int i = 0; i < 20; i++) begin
         S_DATA = 32'h2000_0000 + i;
         #1;
         if (S_READY) sb.push_back(S_DATA);
         tick();
      end
      RESETN  = 1'b0;
      M_READY = 1'b0;
      sb.delete();
      tick();
      tick();
      RESETN  = 1'b1;
      S_VALID = 1'b0;
      #1;
      check("mrst_m_valid", M_VALID, 0);
      check("mrst_level", LEVEL, 0);
      check("mrst_s_ready", S_READY, 1);
      check("mrst_w_en", W_EN, 0);
      check("mrst_ovf", OVERFLOW, 0);
      check("mrst_r_addr", R_ADDR, 0);
      M_READY = 1'b1;
      repeat (8) tick();

      // throughput
      bad_rdy = 0;
      gaps    = 0;
      for (int i = 0; i < 1000; i++) begin
         S_VALID = 1'b1;
         S_DATA  = 32'h3000_0000 + i;
         #1;
         if (!S_READY) bad_rdy++;
         else sb.push_back(S_DATA);
         if (i >= 6 && !M_VALID) gaps++;
         tick();
      end
      S_VALID = 1'b0;
      check("thru_ready", bad_rdy, 0);
      check("thru_gaps", gaps, 0);
      wait_drain("thru_drain", 20);

      // flush with data stored and reads in flight
      M_READY = 1'b0;
      for (int i = 0; i < 500; i++) begin
         S_VALID = 1'b1;
         S_DATA  = 32'h4000_0000 + i;
         #1;
         sb.push_back(S_DATA);
         tick();
      end
      S_VALID = 1'b0;
      repeat (5) tick();
      M_READY = 1'b1;
      tick();
      tick();
      M_READY = 1'b0;
      FLUSH   = 1'b1;
      S_VALID = 1'b1;
      S_DATA  = 32'h55;
      sb.delete();
      #1;
      check("flush_w_en", W_EN, 0);
      tick();
      FLUSH   = 1'b0;
      S_VALID = 1'b0;
      #1;
      check("flush_level", LEVEL, 0);
      check("flush_m_valid", M_VALID, 0);
      check("flush_ovf", OVERFLOW, 0);
      check("flush_s_ready", S_READY, 1);
      M_READY = 1'b1;
      stale   = 0;
      for (int i = 0; i < 6; i++) begin
         if (M_VALID) stale++;
         tick();
      end
      check("flush_no_stale", stale, 0);
      S_VALID = 1'b1;
      S_DATA  = 32'h1;
      #1;
      check("flush_first_waddr", W_ADDR, 0);
      sb.push_back(32'h1);
      tick();
      S_VALID = 1'b0;
      wait_drain("flush_first_out", 10);
      repeat (2) tick();
      check("flush_final_level", LEVEL, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
